// File: rtl/puf_meas_ctrl.sv
// Ring-oscillator PUF measurement sequencer.
// On a start request it walks C_OIDWIDTH challenges from challenge memory.
// Each challenge names an oscillator pair. A valid pair is reset, counted for
// a fixed window, allowed to settle and then compared to produce one ID bit.
// An invalid pair yields a 0 bit and raises the sticky error flag.
module puf_meas_ctrl #(
    parameter int C_IOSCNUM      = 10,
    parameter int C_IOSCDWIDTH   = 24,
    parameter int C_OIDWIDTH     = 24,
    parameter int C_MEMDATAWIDTH = 8,
    parameter int C_MEMADDRWIDTH = 24,
    parameter int C_SELWIDTH     = 4,
    parameter int C_BASEADDR     = 0,
    parameter int C_RSTCYC       = 4,
    parameter int C_WINDOW       = 1000,
    parameter int C_SETTLE       = 4
) (
    input  logic                      I_sclk,
    input  logic                      I_rst,
    input  logic                      I_start,
    output logic                      O_busy,
    output logic                      O_done,
    output logic [C_MEMADDRWIDTH-1:0] O_mem_addr,
    input  logic [C_MEMDATAWIDTH-1:0] I_mem_data,
    output logic [C_SELWIDTH-1:0]     O_osc_sel_a,
    output logic [C_SELWIDTH-1:0]     O_osc_sel_b,
    output logic                      O_osc_rst,
    output logic                      O_cnt_en,
    input  logic [C_IOSCDWIDTH-1:0]   I_cnt_a,
    input  logic [C_IOSCDWIDTH-1:0]   I_cnt_b,
    output logic [C_OIDWIDTH-1:0]     O_prim_id,
    output logic                      O_err
);

    // Shared duration timer only needs to hold the longest phase length minus one.
    localparam int C_TMAX = (C_RSTCYC > C_WINDOW) ?
                            ((C_RSTCYC > C_SETTLE) ? C_RSTCYC : C_SETTLE) :
                            ((C_WINDOW > C_SETTLE) ? C_WINDOW : C_SETTLE);
    localparam int C_TW   = (C_TMAX > 1) ? $clog2(C_TMAX) : 1;
    localparam int C_KW   = (C_OIDWIDTH > 1) ? $clog2(C_OIDWIDTH) : 1;

    localparam logic [C_TW-1:0]       C_T_RST  = C_TW'(C_RSTCYC - 1);
    localparam logic [C_TW-1:0]       C_T_WIN  = C_TW'(C_WINDOW - 1);
    localparam logic [C_TW-1:0]       C_T_SET  = C_TW'(C_SETTLE - 1);
    localparam logic [C_TW-1:0]       C_T_ZERO = C_TW'(0);
    localparam logic [C_TW-1:0]       C_T_ONE  = C_TW'(1);
    localparam logic [C_KW-1:0]       C_K_LAST = C_KW'(C_OIDWIDTH - 1);
    localparam logic [C_KW-1:0]       C_K_ZERO = C_KW'(0);
    localparam logic [C_KW-1:0]       C_K_ONE  = C_KW'(1);
    localparam logic [C_SELWIDTH:0]   C_NOSC   = (C_SELWIDTH + 1)'(C_IOSCNUM);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_FETCH   = 4'd2,
        S_MEMWAIT = 4'd3,
        S_CHECK   = 4'd4,
        S_OSCRST  = 4'd5,
        S_COUNT   = 4'd6,
        S_SETTLE  = 4'd7,
        S_COMPARE = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    // Challenge address for bit index k.
    function automatic logic [C_MEMADDRWIDTH-1:0] addr_of(input logic [C_KW-1:0] k);
        return C_MEMADDRWIDTH'(C_BASEADDR) + C_MEMADDRWIDTH'(k);
    endfunction

    state_t                    r_state;
    logic [C_TW-1:0]           r_timer;
    logic [C_KW-1:0]           r_k;
    logic [C_SELWIDTH-1:0]     r_pair_a;
    logic [C_SELWIDTH-1:0]     r_pair_b;
    logic [C_SELWIDTH-1:0]     r_sel_a;
    logic [C_SELWIDTH-1:0]     r_sel_b;
    logic [C_MEMADDRWIDTH-1:0] r_mem_addr;
    logic [C_OIDWIDTH-1:0]     r_prim_id;
    logic                      r_err;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_osc_rst;
    logic                      r_cnt_en;

    state_t                    w_state_nxt;
    logic [C_TW-1:0]           w_timer_nxt;
    logic [C_KW-1:0]           w_k_nxt;
    logic [C_SELWIDTH-1:0]     w_pair_a_nxt;
    logic [C_SELWIDTH-1:0]     w_pair_b_nxt;
    logic [C_SELWIDTH-1:0]     w_sel_a_nxt;
    logic [C_SELWIDTH-1:0]     w_sel_b_nxt;
    logic [C_MEMADDRWIDTH-1:0] w_mem_addr_nxt;
    logic [C_OIDWIDTH-1:0]     w_prim_id_nxt;
    logic                      w_err_nxt;

    // Advance to the next challenge (or finish) after a CHECK or COMPARE exit.
    logic                      w_last;
    logic [C_KW-1:0]           w_k_inc;
    state_t                    w_adv_state;
    logic [C_KW-1:0]           w_adv_k;
    logic [C_MEMADDRWIDTH-1:0] w_adv_addr;
    logic                      w_pair_bad;

    assign w_last      = (r_k == C_K_LAST);
    assign w_k_inc     = r_k + C_K_ONE;
    assign w_adv_state = w_last ? S_DONE : S_FETCH;
    assign w_adv_k     = w_last ? r_k : w_k_inc;
    assign w_adv_addr  = w_last ? r_mem_addr : addr_of(w_k_inc);
    assign w_pair_bad  = ({1'b0, r_pair_a} >= C_NOSC) ||
                         ({1'b0, r_pair_b} >= C_NOSC) ||
                         (r_pair_a == r_pair_b);

    // Next-state and datapath update for the measurement sequence.
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_k_nxt        = r_k;
        w_pair_a_nxt   = r_pair_a;
        w_pair_b_nxt   = r_pair_b;
        w_sel_a_nxt    = r_sel_a;
        w_sel_b_nxt    = r_sel_b;
        w_mem_addr_nxt = r_mem_addr;
        w_prim_id_nxt  = r_prim_id;
        w_err_nxt      = r_err;
        case (r_state)
            S_IDLE: begin
                if (I_start) begin
                    w_prim_id_nxt = '0;
                    w_err_nxt     = 1'b0;
                    w_k_nxt       = C_K_ZERO;
                    w_state_nxt   = S_LOAD;
                end else begin
                    w_state_nxt   = S_IDLE;
                end
            end
            S_LOAD: begin
                w_mem_addr_nxt = addr_of(r_k);
                w_state_nxt    = S_FETCH;
            end
            S_FETCH: begin
                w_state_nxt = S_MEMWAIT;
            end
            S_MEMWAIT: begin
                w_pair_a_nxt = I_mem_data[2*C_SELWIDTH-1:C_SELWIDTH];
                w_pair_b_nxt = I_mem_data[C_SELWIDTH-1:0];
                w_state_nxt  = S_CHECK;
            end
            S_CHECK: begin
                if (w_pair_bad) begin
                    w_prim_id_nxt[r_k] = 1'b0;
                    w_err_nxt          = 1'b1;
                    w_k_nxt            = w_adv_k;
                    w_mem_addr_nxt     = w_adv_addr;
                    w_state_nxt        = w_adv_state;
                end else begin
                    w_sel_a_nxt = r_pair_a;
                    w_sel_b_nxt = r_pair_b;
                    w_timer_nxt = C_T_RST;
                    w_state_nxt = S_OSCRST;
                end
            end
            S_OSCRST: begin
                if (r_timer == C_T_ZERO) begin
                    w_timer_nxt = C_T_WIN;
                    w_state_nxt = S_COUNT;
                end else begin
                    w_timer_nxt = r_timer - C_T_ONE;
                end
            end
            S_COUNT: begin
                if (r_timer == C_T_ZERO) begin
                    w_timer_nxt = C_T_SET;
                    w_state_nxt = S_SETTLE;
                end else begin
                    w_timer_nxt = r_timer - C_T_ONE;
                end
            end
            S_SETTLE: begin
                if (r_timer == C_T_ZERO) begin
                    w_state_nxt = S_COMPARE;
                end else begin
                    w_timer_nxt = r_timer - C_T_ONE;
                end
            end
            S_COMPARE: begin
                w_prim_id_nxt[r_k] = (I_cnt_a > I_cnt_b);
                w_k_nxt            = w_adv_k;
                w_mem_addr_nxt     = w_adv_addr;
                w_state_nxt        = w_adv_state;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; control outputs follow the next state so they line up with it.
    always_ff @(posedge I_sclk) begin
        if (I_rst) begin
            r_state    <= S_IDLE;
            r_timer    <= C_T_ZERO;
            r_k        <= C_K_ZERO;
            r_pair_a   <= '0;
            r_pair_b   <= '0;
            r_sel_a    <= '0;
            r_sel_b    <= '0;
            r_mem_addr <= '0;
            r_prim_id  <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_osc_rst  <= 1'b1;
            r_cnt_en   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_k        <= w_k_nxt;
            r_pair_a   <= w_pair_a_nxt;
            r_pair_b   <= w_pair_b_nxt;
            r_sel_a    <= w_sel_a_nxt;
            r_sel_b    <= w_sel_b_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_prim_id  <= w_prim_id_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
            r_osc_rst  <= !((w_state_nxt == S_COUNT) || (w_state_nxt == S_SETTLE));
            r_cnt_en   <= (w_state_nxt == S_COUNT);
        end
    end

    assign O_busy      = r_busy;
    assign O_done      = r_done;
    assign O_mem_addr  = r_mem_addr;
    assign O_osc_sel_a = r_sel_a;
    assign O_osc_sel_b = r_sel_b;
    assign O_osc_rst   = r_osc_rst;
    assign O_cnt_en    = r_cnt_en;
    assign O_prim_id   = r_prim_id;
    assign O_err       = r_err;

endmodule

// File: tb/tb_puf_meas_ctrl.sv
// Self-checking bench for puf_meas_ctrl: directed and randomized runs
// compared against a challenge-level reference model.
module tb_puf_meas_ctrl;

    localparam int NID       = 24;
    localparam int VALID_CYC = 4 + 4 + 1000 + 4;
    localparam int BAD_CYC   = 3;

    logic        I_sclk = 1'b0;
    logic        I_rst  = 1'b1;
    logic        I_start = 1'b0;
    logic        O_busy, O_done, O_osc_rst, O_cnt_en, O_err;
    logic [23:0] O_mem_addr;
    logic [7:0]  I_mem_data = 8'h00;
    logic [3:0]  O_osc_sel_a, O_osc_sel_b;
    logic [23:0] I_cnt_a, I_cnt_b, O_prim_id;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0]  mem     [0:NID-1];
    logic [23:0] osc_cnt [0:15];

    puf_meas_ctrl dut (
        .I_sclk(I_sclk), .I_rst(I_rst), .I_start(I_start),
        .O_busy(O_busy), .O_done(O_done), .O_mem_addr(O_mem_addr),
        .I_mem_data(I_mem_data), .O_osc_sel_a(O_osc_sel_a), .O_osc_sel_b(O_osc_sel_b),
        .O_osc_rst(O_osc_rst), .O_cnt_en(O_cnt_en), .I_cnt_a(I_cnt_a), .I_cnt_b(I_cnt_b),
        .O_prim_id(O_prim_id), .O_err(O_err)
    );

    always #5 I_sclk = ~I_sclk;

    // cycle counter
    always @(posedge I_sclk) cyc <= cyc + 1;

    // challenge memory with one-cycle registered read; counts follow the selects
    always @(posedge I_sclk)
        I_mem_data <= (O_mem_addr < 24'd24) ? mem[O_mem_addr[4:0]] : 8'hFF;
    assign I_cnt_a = osc_cnt[O_osc_sel_a];
    assign I_cnt_b = osc_cnt[O_osc_sel_b];

    // bus monitor: records run edges, done pulses, window lengths and fetched addresses
    logic        busy_prev  = 1'b0;
    int          en_run = 0, rl_run = 0, done_total = 0;
    int          done_cyc = 0, rise_cyc = 0, fall_cyc = 0;
    int          en_lens[$];
    int          rl_lens[$];
    logic [23:0] addr_q[$];

    always @(negedge I_sclk) begin
        busy_prev <= O_busy;
        if (O_busy && !busy_prev) begin
            rise_cyc <= cyc;
            addr_q.delete();
            en_lens.delete();
            rl_lens.delete();
        end
        if (!O_busy && busy_prev) fall_cyc <= cyc;
        if (O_done) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc;
        end
        if (O_busy && busy_prev && (addr_q.size() == 0 || addr_q[$] != O_mem_addr))
            addr_q.push_back(O_mem_addr);
        if (O_cnt_en) en_run <= en_run + 1;
        else if (en_run != 0) begin
            en_lens.push_back(en_run);
            en_run <= 0;
        end
        if (!O_osc_rst) rl_run <= rl_run + 1;
        else if (rl_run != 0) begin
            rl_lens.push_back(rl_run);
            rl_run <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge I_sclk);
        #1;
    endtask

    // Reference model: per-challenge rules applied to the memory image and oscillator counts.
    task automatic model(output logic [23:0] id, output logic err, output int nval, output int tcyc);
        logic [3:0] a, b;
        id = '0; err = 1'b0; nval = 0; tcyc = 0;
        for (int k = 0; k < NID; k++) begin
            a = mem[k][7:4];
            b = mem[k][3:0];
            if (a < 4'd10 && b < 4'd10 && a != b) begin
                nval++;
                tcyc += VALID_CYC;
                id[k] = (osc_cnt[a] > osc_cnt[b]);
            end else begin
                tcyc += BAD_CYC;
                err = 1'b1;
            end
        end
    endtask

    task automatic start_run(input string tag);
        I_start = 1'b1;
        step();
        I_start = 1'b0;
        chk({tag, ".busy_up"}, 64'(O_busy), 64'd1);
    endtask

    // Wait for completion of the running run and compare everything against the model.
    task automatic wait_run(input string tag, input bit poke, input bit restart);
        logic [23:0] exp_id;
        logic        exp_err;
        int          nval, tcyc, d0, bad;
        bit          seen;
        model(exp_id, exp_err, nval, tcyc);
        d0   = done_total;
        seen = 0;
        for (int i = 0; i < tcyc + 20; i++) begin
            step();
            I_start = (poke && (i == 7 || i == tcyc / 2)) ? 1'b1 : 1'b0;
            if (O_done) begin
                seen = 1;
                break;
            end
        end
        I_start = 1'b0;
        chk({tag, ".done_seen"}, 64'(seen), 64'd1);
        chk({tag, ".done_time"}, 64'(done_cyc - rise_cyc), 64'(tcyc + 1));
        chk({tag, ".done_count"}, 64'(done_total - d0), 64'd1);
        chk({tag, ".prim_id"}, 64'(O_prim_id), 64'(exp_id));
        chk({tag, ".err"}, 64'(O_err), 64'(exp_err));
        chk({tag, ".n_windows"}, 64'(en_lens.size()), 64'(nval));
        chk({tag, ".n_rst_low"}, 64'(rl_lens.size()), 64'(nval));
        bad = 0;
        foreach (en_lens[i]) if (en_lens[i] != 1000) bad++;
        foreach (rl_lens[i]) if (rl_lens[i] != 1004) bad++;
        chk({tag, ".window_len"}, 64'(bad), 64'd0);
        bad = 0;
        foreach (addr_q[i]) if (addr_q[i] != 24'(i)) bad++;
        chk({tag, ".addr_count"}, 64'(addr_q.size()), 64'(NID));
        chk({tag, ".addr_seq"}, 64'(bad), 64'd0);
        if (restart) begin
            I_start = 1'b1;
            step();
            chk({tag, ".start_in_done_dropped"}, 64'(O_busy), 64'd0);
            chk({tag, ".busy_fall"}, 64'(fall_cyc - done_cyc), 64'd1);
            step();
            I_start = 1'b0;
            chk({tag, ".restart_busy"}, 64'(O_busy), 64'd1);
            chk({tag, ".restart_clr_id"}, 64'(O_prim_id), 64'd0);
            chk({tag, ".restart_clr_err"}, 64'(O_err), 64'd0);
        end else begin
            step();
            chk({tag, ".busy_down"}, 64'(O_busy), 64'd0);
            chk({tag, ".busy_fall"}, 64'(fall_cyc - done_cyc), 64'd1);
        end
    endtask

    // Random challenge image: roughly 30% valid, the rest spread over the invalid cases.
    task automatic rand_mem();
        logic [3:0] a, b;
        int r;
        for (int k = 0; k < NID; k++) begin
            r = $urandom_range(0, 99);
            if (r < 30) begin
                a = 4'($urandom_range(0, 9));
                b = 4'($urandom_range(0, 8));
                if (b >= a) b = b + 4'd1;
            end else if (r < 55) begin
                a = 4'($urandom_range(0, 15));
                b = a;
            end else if (r < 80) begin
                a = 4'($urandom_range(10, 15));
                b = 4'($urandom_range(0, 15));
            end else begin
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(10, 15));
            end
            mem[k] = {a, b};
        end
        for (int i = 0; i < 16; i++) osc_cnt[i] = 24'($urandom);
    endtask

    initial begin
        int d0;
        bit seen;
        for (int k = 0; k < NID; k++) mem[k] = 8'h01;
        for (int i = 0; i < 16; i++) osc_cnt[i] = 24'd0;
        osc_cnt[0] = 24'd500;
        osc_cnt[1] = 24'd400;

        // reset state
        I_rst = 1'b1;
        repeat (3) step();
        I_rst = 1'b0;
        step();
        chk("rst.busy", 64'(O_busy), 64'd0);
        chk("rst.done", 64'(O_done), 64'd0);
        chk("rst.addr", 64'(O_mem_addr), 64'd0);
        chk("rst.sel", 64'({O_osc_sel_a, O_osc_sel_b}), 64'd0);
        chk("rst.osc_rst", 64'(O_osc_rst), 64'd1);
        chk("rst.cnt_en", 64'(O_cnt_en), 64'd0);
        chk("rst.prim_id", 64'(O_prim_id), 64'd0);
        chk("rst.err", 64'(O_err), 64'd0);

        // T1: reset in the middle of a counting window aborts the run
        start_run("t1");
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (O_cnt_en) begin
                seen = 1;
                break;
            end
        end
        chk("t1.window_open", 64'(seen), 64'd1);
        repeat (100) step();
        d0 = done_total;
        I_rst = 1'b1;
        repeat (3) step();
        I_rst = 1'b0;
        step();
        chk("t1.busy", 64'(O_busy), 64'd0);
        chk("t1.osc_rst", 64'(O_osc_rst), 64'd1);
        chk("t1.cnt_en", 64'(O_cnt_en), 64'd0);
        chk("t1.prim_id", 64'(O_prim_id), 64'd0);
        repeat (30) step();
        chk("t1.no_done", 64'(done_total - d0), 64'd0);
        chk("t1.idle_busy", 64'(O_busy), 64'd0);

        // T2: full run of valid pairs with count A above count B
        start_run("t2");
        wait_run("t2", 1'b0, 1'b0);
        chk("t2.all_ones", 64'(O_prim_id), 64'hFFFFFF);

        // T3/T4: pair (2,3) compare boundaries; invalid pairs 4/4 and 10/0 at bits 5,6
        for (int k = 0; k < NID; k++) mem[k] = 8'hFF;
        mem[0] = 8'h23;
        mem[5] = 8'h44;
        mem[6] = 8'hA0;
        osc_cnt[2] = 24'd777; osc_cnt[3] = 24'd777;
        start_run("t3_tie");
        wait_run("t3_tie", 1'b0, 1'b0);
        chk("t3_tie.bit0", 64'(O_prim_id[0]), 64'd0);
        osc_cnt[2] = 24'd776;
        start_run("t3_less");
        wait_run("t3_less", 1'b0, 1'b0);
        chk("t3_less.bit0", 64'(O_prim_id[0]), 64'd0);
        osc_cnt[2] = 24'd778;
        start_run("t3_more");
        wait_run("t3_more", 1'b0, 1'b0);
        chk("t3_more.bit0", 64'(O_prim_id[0]), 64'd1);
        chk("t4.bits56", 64'(O_prim_id[6:5]), 64'd0);
        chk("t4.err", 64'(O_err), 64'd1);

        // T6: starts while busy and in DONE are dropped; start right after DONE restarts
        mem[1] = 8'h01;
        mem[2] = 8'h01;
        start_run("t6a");
        wait_run("t6a", 1'b1, 1'b1);
        wait_run("t6b", 1'b0, 1'b0);

        // randomized runs, extreme and tied counts mixed in
        for (int r = 0; r < 3; r++) begin
            rand_mem();
            if (r == 1) begin
                osc_cnt[4] = 24'hFFFFFF;
                osc_cnt[5] = 24'h000000;
                osc_cnt[7] = osc_cnt[6];
                mem[0] = 8'h45;
                mem[1] = 8'h54;
                mem[2] = 8'h67;
            end
            start_run("rnd");
            wait_run("rnd", r[0], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
